// File: rtl/move_eval_seq.sv
// move_eval_seq: walks a move list one candidate at a time, presents each
// board/move to the evaluate and board_attack stages, and keeps the best
// result for the side to move.
//
// Optional feature macro: EVAL_TIMEOUT_EN adds an EVAL watchdog and a sticky
// timeout output. Without it, EVAL waits for eval_valid indefinitely.
//
// Board width comes from the `BOARD_WIDTH macro (defaults to 64 here).
//
// Handshake: board_valid is a level that stays high for the whole EVAL state;
// the first cycle with board_valid=1 and eval_valid=1 transfers one result.
// eval_valid seen while board_valid=0 carries no meaning and is dropped.
`ifndef BOARD_WIDTH
`define BOARD_WIDTH 64
`endif

module move_eval_seq #(
  parameter int EVAL_WIDTH      = 24,
  parameter int UCI_WIDTH       = 16,
  parameter int MOVE_ADDR_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [MOVE_ADDR_WIDTH-1:0]   move_count,
  input  logic                         white_to_move,
  output logic [MOVE_ADDR_WIDTH-1:0]   move_addr,
  input  logic [`BOARD_WIDTH-1:0]      move_board,
  input  logic [UCI_WIDTH-1:0]         move_uci,
  output logic [`BOARD_WIDTH-1:0]      board_out,
  output logic [UCI_WIDTH-1:0]         uci_out,
  output logic                         board_valid,
  output logic                         clear_eval,
  output logic                         clear_attack,
  input  logic signed [EVAL_WIDTH-1:0] eval,
  input  logic                         eval_valid,
  output logic signed [EVAL_WIDTH-1:0] best_eval,
  output logic [UCI_WIDTH-1:0]         best_uci,
  output logic [MOVE_ADDR_WIDTH-1:0]   best_index,
  output logic                         busy,
  output logic                         done,
`ifdef EVAL_TIMEOUT_EN
  output logic                         timeout,
`endif
  output logic [2:0]                   state_dbg_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_EVAL  = 3'd3,
    S_CLEAR = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t                         state_q, state_d;
  logic [MOVE_ADDR_WIDTH-1:0]     idx_q;
  logic [MOVE_ADDR_WIDTH-1:0]     count_q;
  logic                           wtm_q;
  logic [`BOARD_WIDTH-1:0]        board_q;
  logic [UCI_WIDTH-1:0]           uci_q;
  logic signed [EVAL_WIDTH-1:0]   best_eval_q;
  logic [UCI_WIDTH-1:0]           best_uci_q;
  logic [MOVE_ADDR_WIDTH-1:0]     best_index_q;
  logic                           have_best_q;

  logic start_go;
  logic accept;
  logic better;
  logic last_move;
  logic eval_exit;

  assign start_go  = (state_q == S_IDLE) && start;
  assign accept    = (state_q == S_EVAL) && eval_valid;
  // The first accepted result always wins; afterwards only a strict
  // improvement for the side to move replaces it, so ties keep the earlier index.
  assign better    = !have_best_q ||
                     (wtm_q ? (eval > best_eval_q) : (eval < best_eval_q));
  // Widened by one bit so the increment can never wrap before the compare.
  assign last_move = ({1'b0, idx_q} + (MOVE_ADDR_WIDTH+1)'(1)) >= {1'b0, count_q};

`ifdef EVAL_TIMEOUT_EN
  logic [9:0] wd_q;
  logic       timeout_q;
  logic       wd_expire;

  assign wd_expire = (state_q == S_EVAL) && !eval_valid && (wd_q == 10'd1023);
  assign eval_exit = eval_valid || wd_expire;

  // Watchdog counts cycles spent in EVAL; restarts from zero on every entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_q <= '0;
    end else if (state_q == S_EVAL) begin
      wd_q <= wd_q + 10'd1;
    end else begin
      wd_q <= '0;
    end
  end

  // Sticky timeout flag: set when a move is skipped, cleared by the next start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timeout_q <= 1'b0;
    end else if (start_go) begin
      timeout_q <= 1'b0;
    end else if (wd_expire) begin
      timeout_q <= 1'b1;
    end
  end

  assign timeout = timeout_q;
`else
  assign eval_exit = eval_valid;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = (move_count != '0) ? S_FETCH : S_DONE;
      S_FETCH: state_d = S_LOAD;
      S_LOAD:  state_d = S_EVAL;
      S_EVAL:  if (eval_exit) state_d = S_CLEAR;
      S_CLEAR: state_d = last_move ? S_DONE : S_FETCH;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    busy         = (state_q != S_IDLE);
    done         = (state_q == S_DONE);
    board_valid  = (state_q == S_EVAL);
    clear_eval   = (state_q == S_CLEAR);
    clear_attack = (state_q == S_CLEAR);
    move_addr    = (state_q == S_FETCH) ? idx_q : '0;
    state_dbg_o  = state_q;
  end

  // Datapath: sequence setup, move load, index advance and best tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q        <= '0;
      count_q      <= '0;
      wtm_q        <= 1'b0;
      board_q      <= '0;
      uci_q        <= '0;
      best_eval_q  <= '0;
      best_uci_q   <= '0;
      best_index_q <= '0;
      have_best_q  <= 1'b0;
    end else begin
      if (start_go) begin
        count_q      <= move_count;
        wtm_q        <= white_to_move;
        idx_q        <= '0;
        best_eval_q  <= '0;
        best_uci_q   <= '0;
        best_index_q <= '1;  // all-ones marks "no move chosen"
        have_best_q  <= 1'b0;
      end
      if (state_q == S_LOAD) begin
        board_q <= move_board;
        uci_q   <= move_uci;
      end
      if (accept && better) begin
        best_eval_q  <= eval;
        best_uci_q   <= uci_q;
        best_index_q <= idx_q;
        have_best_q  <= 1'b1;
      end
      if (state_q == S_CLEAR) begin
        idx_q <= idx_q + MOVE_ADDR_WIDTH'(1);
      end
    end
  end

  assign board_out  = board_q;
  assign uci_out    = uci_q;
  assign best_eval  = best_eval_q;
  assign best_uci   = best_uci_q;
  assign best_index = best_index_q;

endmodule

// File: tb/tb_move_eval_seq.sv
// Testbench for move_eval_seq: move-list memory model, evaluate-stage
// responder, scoreboard of expected best results, scenario tasks.
`ifndef BOARD_WIDTH
`define BOARD_WIDTH 64
`endif

module tb_move_eval_seq;

  localparam int EW     = 24;
  localparam int UW     = 16;
  localparam int AW     = 8;
  localparam int BW     = `BOARD_WIDTH;
  localparam int BUDGET = 5000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic                 start;
  logic [AW-1:0]        move_count;
  logic                 white_to_move;
  logic [AW-1:0]        move_addr;
  logic [BW-1:0]        move_board;
  logic [UW-1:0]        move_uci;
  logic [BW-1:0]        board_out;
  logic [UW-1:0]        uci_out;
  logic                 board_valid;
  logic                 clear_eval;
  logic                 clear_attack;
  logic signed [EW-1:0] eval;
  logic                 eval_valid;
  logic signed [EW-1:0] best_eval;
  logic [UW-1:0]        best_uci;
  logic [AW-1:0]        best_index;
  logic                 busy;
  logic                 done;
  logic [2:0]           state_dbg;
`ifdef EVAL_TIMEOUT_EN
  logic                 timeout;
`endif

  move_eval_seq #(.EVAL_WIDTH(EW), .UCI_WIDTH(UW), .MOVE_ADDR_WIDTH(AW)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .move_count    (move_count),
    .white_to_move (white_to_move),
    .move_addr     (move_addr),
    .move_board    (move_board),
    .move_uci      (move_uci),
    .board_out     (board_out),
    .uci_out       (uci_out),
    .board_valid   (board_valid),
    .clear_eval    (clear_eval),
    .clear_attack  (clear_attack),
    .eval          (eval),
    .eval_valid    (eval_valid),
    .best_eval     (best_eval),
    .best_uci      (best_uci),
    .best_index    (best_index),
    .busy          (busy),
    .done          (done),
`ifdef EVAL_TIMEOUT_EN
    .timeout       (timeout),
`endif
    .state_dbg_o   (state_dbg)
  );

  // ---------------- move list model (one-cycle read latency) ----------------
  logic [BW-1:0] board_mem [256];
  logic [UW-1:0] uci_mem   [256];
  int            eval_tab  [256];
  bit            withhold  [256];

  always @(posedge clk) begin
    move_board <= board_mem[move_addr];
    move_uci   <= uci_mem[move_addr];
  end

  // ---------------- evaluate-stage responder ----------------
  // Answers lat cycles after board_valid rises, keyed by the index stamped
  // into the low byte of the board. Outside EVAL it optionally drives noise.
  int lat;
  bit noise;
  int noise_val;

  initial begin
    int cnt;
    int mi;
    cnt        = 0;
    eval_valid = 1'b0;
    eval       = '0;
    forever begin
      @(negedge clk);
      mi = int'(board_out[7:0]);
      if (board_valid) begin
        if (cnt == lat && !withhold[mi]) begin
          eval_valid = 1'b1;
          eval       = EW'(eval_tab[mi]);
        end else begin
          eval_valid = 1'b0;
        end
        cnt++;
      end else begin
        cnt        = 0;
        eval_valid = noise;
        eval       = EW'(noise_val);
      end
    end
  end

  // ---------------- pulse monitors ----------------
  int n_done, n_bv, n_clr_e, n_clr_a, n_clr_pair;

  always @(negedge clk) begin
    if (done)                       n_done++;
    if (board_valid)                n_bv++;
    if (clear_eval)                 n_clr_e++;
    if (clear_attack)               n_clr_a++;
    if (clear_eval && clear_attack) n_clr_pair++;
  end

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [EW-1:0] exp_eval_q [$];
  logic [AW-1:0] exp_idx_q  [$];
  logic [UW-1:0] exp_uci_q  [$];

  task automatic push_expect(input int n, input bit wtm);
    int best;
    int bi;
    bit have;
    best = 0;
    bi   = 0;
    have = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (!withhold[i] && (!have || (wtm ? (eval_tab[i] > best) : (eval_tab[i] < best)))) begin
        best = eval_tab[i];
        bi   = i;
        have = 1'b1;
      end
    end
    exp_eval_q.push_back(EW'(best));
    exp_idx_q.push_back(have ? AW'(bi) : {AW{1'b1}});
    exp_uci_q.push_back(have ? uci_mem[bi] : '0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic fill_moves(input int n);
    for (int i = 0; i < n; i++) begin
      board_mem[i]      = BW'({$urandom(), $urandom()});
      board_mem[i][7:0] = 8'(i);
      uci_mem[i]        = UW'($urandom());
      withhold[i]       = 1'b0;
    end
  endtask

  // Starts a sequence and returns the number of negedges from the start
  // sampling edge up to the one where done is seen. Optionally pokes start
  // while busy to confirm it is ignored.
  task automatic run_seq(input int n, input bit wtm, input bit poke,
                         output int cycles, output bit timed_out);
    @(negedge clk);
    n_done = 0; n_bv = 0; n_clr_e = 0; n_clr_a = 0; n_clr_pair = 0;
    start         = 1'b1;
    move_count    = AW'(n);
    white_to_move = wtm;
    @(negedge clk);
    start      = 1'b0;
    move_count = '0;
    cycles     = 1;
    timed_out  = 1'b0;
    while (!done) begin
      if (cycles >= BUDGET) begin
        timed_out = 1'b1;
        break;
      end
      @(negedge clk);
      cycles++;
      if (poke && cycles == 3) begin
        start         = 1'b1;
        move_count    = '0;
        white_to_move = !wtm;
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, board_valid, clear_eval, clear_attack} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=00000", {busy, done, board_valid, clear_eval, clear_attack});
    end
    checks++;
    if (move_addr !== '0 || board_out !== '0 || uci_out !== '0) begin
      failures++;
      $display("FAIL reset_data addr=%h uci=%h exp=0", move_addr, uci_out);
    end
    checks++;
    if (best_eval !== '0 || best_uci !== '0 || best_index !== '0) begin
      failures++;
      $display("FAIL reset_best eval=%0d uci=%h idx=%h exp=0", best_eval, best_uci, best_index);
    end
    checks++;
    if (state_dbg !== 3'd0) begin
      failures++;
      $display("FAIL reset_state got=%0d exp=0", state_dbg);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_white();
    int cyc; bit to;
    logic [EW-1:0] ee; logic [AW-1:0] ei; logic [UW-1:0] eu;
    fill_moves(3);
    eval_tab[0] = 10; eval_tab[1] = -5; eval_tab[2] = 40;
    lat = 2; noise = 1'b1; noise_val = 1000;
    push_expect(3, 1'b1);
    run_seq(3, 1'b1, 1'b1, cyc, to);
    ee = exp_eval_q.pop_front(); ei = exp_idx_q.pop_front(); eu = exp_uci_q.pop_front();
    checks++;
    if (to) begin failures++; $display("FAIL white_timeout cycles=%0d", cyc); end
    checks++;
    if (best_eval !== ee) begin failures++; $display("FAIL white_eval got=%0d exp=%0d", best_eval, $signed(ee)); end
    checks++;
    if (best_index !== ei) begin failures++; $display("FAIL white_index got=%0d exp=%0d", best_index, ei); end
    checks++;
    if (best_uci !== eu) begin failures++; $display("FAIL white_uci got=%h exp=%h", best_uci, eu); end
    checks++;
    if (n_done !== 1) begin failures++; $display("FAIL white_done_count got=%0d exp=1", n_done); end
    checks++;
    if (cyc !== 1 + 3 * (4 + 2)) begin failures++; $display("FAIL white_latency got=%0d exp=%0d", cyc, 1 + 3 * 6); end
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL white_idle done=%b busy=%b exp=0", done, busy); end
    noise = 1'b0;
  endtask

  task automatic test_black();
    int cyc; bit to;
    logic [EW-1:0] ee; logic [AW-1:0] ei; logic [UW-1:0] eu;
    fill_moves(3);
    eval_tab[0] = 10; eval_tab[1] = -5; eval_tab[2] = 40;
    lat = 0; noise = 1'b1; noise_val = -1000;
    push_expect(3, 1'b0);
    run_seq(3, 1'b0, 1'b0, cyc, to);
    ee = exp_eval_q.pop_front(); ei = exp_idx_q.pop_front(); eu = exp_uci_q.pop_front();
    checks++;
    if (to) begin failures++; $display("FAIL black_timeout cycles=%0d", cyc); end
    checks++;
    if (best_eval !== ee || best_index !== ei || best_uci !== eu) begin
      failures++;
      $display("FAIL black_best got=%0d/%0d/%h exp=%0d/%0d/%h", best_eval, best_index, best_uci, $signed(ee), ei, eu);
    end
    checks++;
    if (cyc !== 1 + 3 * 4) begin failures++; $display("FAIL black_latency got=%0d exp=13", cyc); end
    noise = 1'b0;
  endtask

  task automatic test_ties();
    int cyc; bit to; bit wtm;
    logic [EW-1:0] ee; logic [AW-1:0] ei; logic [UW-1:0] eu;
    fill_moves(2);
    eval_tab[0] = 7; eval_tab[1] = 7;
    lat = 1;
    wtm = 1'($urandom_range(0, 1));
    push_expect(2, wtm);
    run_seq(2, wtm, 1'b0, cyc, to);
    ee = exp_eval_q.pop_front(); ei = exp_idx_q.pop_front(); eu = exp_uci_q.pop_front();
    checks++;
    if (to) begin failures++; $display("FAIL ties_timeout cycles=%0d", cyc); end
    checks++;
    if (best_index !== ei || best_eval !== ee || best_uci !== eu) begin
      failures++;
      $display("FAIL ties_best got idx=%0d eval=%0d exp idx=%0d eval=%0d", best_index, best_eval, ei, $signed(ee));
    end
    checks++;
    if (n_clr_e !== 2 || n_clr_a !== 2 || n_clr_pair !== 2) begin
      failures++;
      $display("FAIL ties_clears got e=%0d a=%0d pair=%0d exp=2/2/2", n_clr_e, n_clr_a, n_clr_pair);
    end
  endtask

  task automatic test_zero();
    int cyc; bit to;
    logic [EW-1:0] ee; logic [AW-1:0] ei; logic [UW-1:0] eu;
    push_expect(0, 1'b1);
    run_seq(0, 1'b1, 1'b0, cyc, to);
    ee = exp_eval_q.pop_front(); ei = exp_idx_q.pop_front(); eu = exp_uci_q.pop_front();
    checks++;
    if (to || cyc !== 1) begin failures++; $display("FAIL zero_done_latency got=%0d exp=1", cyc); end
    checks++;
    if (best_index !== ei || best_eval !== ee || best_uci !== eu) begin
      failures++;
      $display("FAIL zero_best got idx=%h eval=%0d uci=%h exp idx=%h eval=0 uci=0", best_index, best_eval, best_uci, ei);
    end
    checks++;
    if (n_bv !== 0 || n_done !== 1) begin
      failures++;
      $display("FAIL zero_pulses got bv=%0d done=%0d exp bv=0 done=1", n_bv, n_done);
    end
  endtask

  task automatic test_reset_mid();
    int cyc; bit to; int waited;
    logic [EW-1:0] ee; logic [AW-1:0] ei; logic [UW-1:0] eu;
    fill_moves(3);
    eval_tab[0] = 5; eval_tab[1] = 9; eval_tab[2] = 1;
    lat = 30;
    @(negedge clk);
    n_done = 0;
    start = 1'b1; move_count = 8'd3; white_to_move = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waited = 0;
    while (!(board_valid && board_out[7:0] == 8'd1) && waited < BUDGET) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (waited >= BUDGET) begin failures++; $display("FAIL rmid_reach_eval1 waited=%0d", waited); end
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, board_valid, clear_eval, clear_attack} !== 5'b0 || move_addr !== '0) begin
      failures++;
      $display("FAIL rmid_flags got=%b addr=%h exp=0", {busy, done, board_valid, clear_eval, clear_attack}, move_addr);
    end
    checks++;
    if (board_out !== '0 || uci_out !== '0 || best_eval !== '0 || best_uci !== '0 || best_index !== '0) begin
      failures++;
      $display("FAIL rmid_data got eval=%0d idx=%h uci=%h exp=0", best_eval, best_index, uci_out);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (n_done !== 0) begin failures++; $display("FAIL rmid_no_done got=%0d exp=0", n_done); end
    lat = 0;
    push_expect(3, 1'b1);
    run_seq(3, 1'b1, 1'b0, cyc, to);
    ee = exp_eval_q.pop_front(); ei = exp_idx_q.pop_front(); eu = exp_uci_q.pop_front();
    checks++;
    if (to || best_eval !== ee || best_index !== ei || best_uci !== eu || n_done !== 1) begin
      failures++;
      $display("FAIL rmid_restart got=%0d/%0d/%h done=%0d exp=%0d/%0d/%h", best_eval, best_index, best_uci, n_done, $signed(ee), ei, eu);
    end
  endtask

  task automatic test_random();
    int cyc; bit to; int n; bit wtm; int l;
    logic [EW-1:0] ee; logic [AW-1:0] ei; logic [UW-1:0] eu;
    for (int it = 0; it < 8; it++) begin
      n   = $urandom_range(1, 8);
      wtm = 1'($urandom_range(0, 1));
      l   = $urandom_range(0, 3);
      fill_moves(n);
      for (int i = 0; i < n; i++) eval_tab[i] = $urandom_range(0, 40) - 20;
      lat = l; noise = 1'($urandom_range(0, 1)); noise_val = wtm ? 5000 : -5000;
      push_expect(n, wtm);
      run_seq(n, wtm, 1'($urandom_range(0, 1)), cyc, to);
      ee = exp_eval_q.pop_front(); ei = exp_idx_q.pop_front(); eu = exp_uci_q.pop_front();
      checks++;
      if (to || best_eval !== ee || best_index !== ei || best_uci !== eu) begin
        failures++;
        $display("FAIL random_best it=%0d got=%0d/%0d/%h exp=%0d/%0d/%h", it, best_eval, best_index, best_uci, $signed(ee), ei, eu);
      end
      checks++;
      if (cyc !== 1 + n * (4 + l) || n_clr_pair !== n) begin
        failures++;
        $display("FAIL random_timing it=%0d got cyc=%0d clr=%0d exp cyc=%0d clr=%0d", it, cyc, n_clr_pair, 1 + n * (4 + l), n);
      end
    end
    noise = 1'b0;
  endtask

`ifdef EVAL_TIMEOUT_EN
  task automatic test_timeout();
    int cyc; bit to;
    logic [EW-1:0] ee; logic [AW-1:0] ei; logic [UW-1:0] eu;
    fill_moves(2);
    eval_tab[0] = 100; eval_tab[1] = 3;
    withhold[0] = 1'b1;
    lat = 0;
    push_expect(2, 1'b1);
    run_seq(2, 1'b1, 1'b0, cyc, to);
    ee = exp_eval_q.pop_front(); ei = exp_idx_q.pop_front(); eu = exp_uci_q.pop_front();
    checks++;
    if (to || timeout !== 1'b1) begin failures++; $display("FAIL wdog_flag got=%b exp=1", timeout); end
    checks++;
    if (best_eval !== ee || best_index !== ei || best_uci !== eu) begin
      failures++;
      $display("FAIL wdog_best got=%0d/%0d exp=%0d/%0d", best_eval, best_index, $signed(ee), ei);
    end
    checks++;
    if (cyc !== 1 + (4 + 1023) + 4) begin failures++; $display("FAIL wdog_latency got=%0d exp=1032", cyc); end
    withhold[0] = 1'b0;
    push_expect(2, 1'b1);
    run_seq(2, 1'b1, 1'b0, cyc, to);
    ee = exp_eval_q.pop_front(); ei = exp_idx_q.pop_front(); eu = exp_uci_q.pop_front();
    checks++;
    if (to || timeout !== 1'b0 || best_index !== ei || best_eval !== ee) begin
      failures++;
      $display("FAIL wdog_clear got flag=%b idx=%0d exp flag=0 idx=%0d", timeout, best_index, ei);
    end
  endtask
`endif

  // ---------------- global guard ----------------
  initial begin
    #2000000;
    $display("FAIL global_time_limit checks=%0d", checks);
    $fatal(1, "time limit");
  end

  // ---------------- sequence + report ----------------
  initial begin
    start = 1'b0; move_count = '0; white_to_move = 1'b0;
    lat = 0; noise = 1'b0; noise_val = 0;
    for (int i = 0; i < 256; i++) begin
      board_mem[i] = '0; uci_mem[i] = '0; eval_tab[i] = 0; withhold[i] = 1'b0;
    end
    test_reset();
    test_white();
    test_black();
    test_ties();
    test_zero();
    test_reset_mid();
    test_random();
`ifdef EVAL_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
